// File: rtl/vpi_pkg.sv
// ============================================================================
// Module  : vpi_pkg
// Brief   : Shared widths and sample type for the VPI capture return path.
//           Optional macro: VPI_CAPTURE_TS_EN (adds a timestamp field).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vpi_pkg;

    localparam int VPI_DATA_W = 32;
    localparam int VPI_TS_W   = 32;

    typedef struct packed {
`ifdef VPI_CAPTURE_TS_EN
        logic [VPI_TS_W-1:0]   ts;
`endif
        logic [VPI_DATA_W-1:0] data;
    } vpi_sample_t;

endpackage

`default_nettype wire

// File: rtl/vpi_capture_ram.sv
// ============================================================================
// Module  : vpi_capture_ram
// Brief   : DEPTH x WIDTH storage, one synchronous write port and one
//           asynchronous read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vpi_capture_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/vpi_capture_fifo.sv
// ============================================================================
// Module  : vpi_capture_fifo
// Brief   : First-word fall-through capture buffer from DUT samples to a
//           polling host, with saturating overflow counter.
//           Optional macro: VPI_CAPTURE_TS_EN (per-sample cycle timestamps).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vpi_capture_fifo
    import vpi_pkg::*;
#(
    parameter int DATA_W = VPI_DATA_W,
    parameter int DEPTH  = 16,
`ifdef VPI_CAPTURE_TS_EN
    parameter int TS_W   = VPI_TS_W,
`endif
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     host_pop,
    output logic                     host_valid,
    output logic [DATA_W-1:0]        host_data,
`ifdef VPI_CAPTURE_TS_EN
    output logic [TS_W-1:0]          host_ts,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         overflow_cnt
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;
`ifdef VPI_CAPTURE_TS_EN
    localparam int c_ENTRY_W = DATA_W + TS_W;
`else
    localparam int c_ENTRY_W = DATA_W;
`endif
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_CNT_ONE = CNT_W'(1);

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_ovf_cnt;
    logic                 r_loaded;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_rd_entry;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]) &&
                     (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = host_pop && !w_empty;
    assign w_drop  = in_valid && w_full;

`ifdef VPI_CAPTURE_TS_EN
    logic [TS_W-1:0] r_cycle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + TS_W'(1);
        end
    end

    assign w_wr_entry = {r_cycle, in_data};
    assign host_ts    = r_loaded ? w_rd_entry[c_ENTRY_W-1:DATA_W] : '0;
`else
    assign w_wr_entry = in_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ovf_cnt <= '0;
            r_loaded  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_loaded <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_drop && (r_ovf_cnt != c_CNT_MAX)) begin
                r_ovf_cnt <= r_ovf_cnt + c_CNT_ONE;
            end
        end
    end

    vpi_capture_ram #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[c_IDX_W-1:0]),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr[c_IDX_W-1:0]),
        .o_rd_data (w_rd_entry)
    );

    // Storage is never cleared, so the head reads as zero until the first push.
    assign host_data    = r_loaded ? w_rd_entry[DATA_W-1:0] : '0;
    assign in_ready     = !w_full;
    assign host_valid   = !w_empty;
    assign level        = r_wr_ptr - r_rd_ptr;
    assign overflow_cnt = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vpi_capture_fifo.sv
// ============================================================================
// Module  : tb_vpi_capture_fifo
// Brief   : Directed self-checking bench for vpi_capture_fifo.
//           Optional macro: VPI_CAPTURE_TS_EN (enables timestamp checks).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vpi_capture_fifo;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        host_pop;
    logic        host_valid;
    logic [31:0] host_data;
`ifdef VPI_CAPTURE_TS_EN
    logic [31:0] host_ts;
`endif
    logic [4:0]  level;
    logic [15:0] overflow_cnt;

    int n_checks = 0;
    int n_errors = 0;

    vpi_capture_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .host_pop     (host_pop),
        .host_valid   (host_valid),
        .host_data    (host_data),
`ifdef VPI_CAPTURE_TS_EN
        .host_ts      (host_ts),
`endif
        .level        (level),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        host_pop = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Idle after reset
        repeat (4) tick();
        chk("rst_host_valid", host_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow_cnt, 0);
        chk("rst_host_data", host_data, 0);

        // Three pushes then three pops
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_level3", level, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_head", host_data, 64'(i + 1));
            host_pop = 1'b1;
            tick();
            chk("t2_level", level, 64'(2 - i));
        end
        host_pop = 1'b0;
        chk("t2_empty", host_valid, 0);

        // Overfill: 20 pushes into 16 entries
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            tick();
            if (i == 15) chk("t3_ready_full", in_ready, 0);
        end
        in_valid = 1'b0;
        chk("t3_ovf", overflow_cnt, 4);
        chk("t3_level", level, 16);
        chk("t3_head", host_data, 64'h100);

        // Push while full with a concurrent pop: sample is lost
        in_valid = 1'b1;
        in_data  = 32'h200;
        host_pop = 1'b1;
        tick();
        host_pop = 1'b0;
        chk("t4_ovf", overflow_cnt, 5);
        chk("t4_level", level, 15);
        chk("t4_ready", in_ready, 1);
        in_data = 32'h201;
        tick();
        in_valid = 1'b0;
        chk("t4_level_full", level, 16);
        chk("t4_ovf_hold", overflow_cnt, 5);

        // Drain and check order
        for (int i = 0; i < 16; i++) begin
            chk("t3_pop_data", host_data, (i < 15) ? 64'h101 + 64'(i) : 64'h201);
            host_pop = 1'b1;
            tick();
        end
        host_pop = 1'b0;
        chk("t3_drained", host_valid, 0);
        chk("t3_level0", level, 0);

        // Pops on empty, then push with simultaneous pop into empty
        host_pop = 1'b1;
        repeat (3) tick();
        chk("t5_level", level, 0);
        chk("t5_valid", host_valid, 0);
        in_valid = 1'b1;
        in_data  = 32'hA5;
        tick();
        in_valid = 1'b0;
        host_pop = 1'b0;
        chk("t5_valid1", host_valid, 1);
        chk("t5_data", host_data, 64'hA5);
        chk("t5_level1", level, 1);

        // Reset mid-stream discards content
        in_valid = 1'b1;
        in_data  = 32'hCC;
        tick();
        in_valid = 1'b0;
        chk("rs_level_pre", level, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_level", level, 0);
        chk("rs_valid", host_valid, 0);
        chk("rs_data", host_data, 0);
`ifdef VPI_CAPTURE_TS_EN
        chk("rs_ts", host_ts, 0);

        // Counter is 0 right after reset; push on cycles 10 and 13
        repeat (10) tick();
        in_valid = 1'b1;
        in_data  = 32'hB0;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        in_valid = 1'b1;
        in_data  = 32'hB3;
        tick();
        in_valid = 1'b0;
        chk("ts_data0", host_data, 64'hB0);
        chk("ts_first", host_ts, 10);
        host_pop = 1'b1;
        tick();
        host_pop = 1'b0;
        chk("ts_data1", host_data, 64'hB3);
        chk("ts_second", host_ts, 13);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
